// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - 8x8 sprite scan engine emitting clipped pixel writes
module sprite_plotter #(
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] ld_x,
  input  logic [6:0] ld_y,
  input  logic [1:0] sprite_sel,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Screen limits at the 9-bit width of the pixel address, so origins
  // near 255 cannot fold back onto the left/top edge.
  localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
  localparam logic [8:0] SCREEN_H9 = 9'(SCREEN_H);

  state_t     state, state_next;
  logic [5:0] k, k_next;
  logic [7:0] org_x, org_x_next;
  logic [6:0] org_y, org_y_next;
  logic [1:0] sel, sel_next;
  logic [2:0] fg, fg_next;

  logic [7:0] x_next;
  logic [6:0] y_next;
  logic [2:0] colour_next;
  logic       writeEn_next;
  logic       busy_next;
  logic       done_next;

  logic [8:0] px;
  logic [8:0] py;
  logic [7:0] row_bits;
  logic       pix_bit;
  logic       erase_mode;

  // Row byte of the selected bitmap; bit 7 is the leftmost column.
  function automatic logic [7:0] bitmap_row(input logic [1:0] s, input logic [2:0] r);
    logic [7:0] b;
    b = 8'hFF;
    if (s == 2'd0) begin
      case (r)
        3'd0: b = 8'h18;
        3'd1: b = 8'h18;
        3'd2: b = 8'h3C;
        3'd3: b = 8'h7E;
        3'd4: b = 8'hFF;
        3'd5: b = 8'hFF;
        3'd6: b = 8'h24;
        default: b = 8'h24;
      endcase
    end else if (s == 2'd1) begin
      case (r)
        3'd0: b = 8'h81;
        3'd1: b = 8'h42;
        3'd2: b = 8'h3C;
        3'd3: b = 8'h5A;
        3'd4: b = 8'hFF;
        3'd5: b = 8'h3C;
        3'd6: b = 8'h42;
        default: b = 8'h81;
      endcase
    end
    return b;
  endfunction

  // Pixel address and bitmap lookup for the pixel currently being scanned.
  always_comb begin
    erase_mode = sel[1];
    px         = {1'b0, org_x} + {6'b0, k[2:0]};
    py         = {2'b0, org_y} + {6'b0, k[5:3]};
    row_bits   = bitmap_row(sel, k[5:3]);
    pix_bit    = erase_mode ? 1'b1 : row_bits[~k[2:0]];
  end

  // Next-state and next-output logic; writes default off outside SCAN.
  always_comb begin
    state_next   = state;
    k_next       = k;
    org_x_next   = org_x;
    org_y_next   = org_y;
    sel_next     = sel;
    fg_next      = fg;
    x_next       = x;
    y_next       = y;
    colour_next  = colour;
    writeEn_next = 1'b0;
    busy_next    = busy;
    done_next    = 1'b0;
    case (state)
      S_IDLE: begin
        busy_next = 1'b0;
        if (go) begin
          org_x_next = ld_x;
          org_y_next = ld_y;
          sel_next   = sprite_sel;
          fg_next    = colour_in;
          k_next     = 6'd0;
          busy_next  = 1'b1;
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        x_next       = px[7:0];
        y_next       = py[6:0];
        colour_next  = erase_mode ? BG_COLOUR : fg;
        writeEn_next = pix_bit && (px < SCREEN_W9) && (py < SCREEN_H9);
        k_next       = k + 6'd1;
        if (k == 6'd63) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, latched command and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      k       <= 6'd0;
      org_x   <= 8'd0;
      org_y   <= 7'd0;
      sel     <= 2'd0;
      fg      <= 3'd0;
      x       <= 8'd0;
      y       <= 7'd0;
      colour  <= 3'd0;
      writeEn <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      k       <= k_next;
      org_x   <= org_x_next;
      org_y   <= org_y_next;
      sel     <= sel_next;
      fg      <= fg_next;
      x       <= x_next;
      y       <= y_next;
      colour  <= colour_next;
      writeEn <= writeEn_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// tb/tb_sprite_plotter.sv - self-checking bench for sprite_plotter
module tb_sprite_plotter;

  logic       clk;
  logic       reset;
  logic       go;
  logic [7:0] ld_x;
  logic [6:0] ld_y;
  logic [1:0] sprite_sel;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn;
  logic       busy;
  logic       done;

  sprite_plotter dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .ld_x       (ld_x),
    .ld_y       (ld_y),
    .sprite_sel (sprite_sel),
    .colour_in  (colour_in),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .writeEn    (writeEn),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: t = edges elapsed since the accepting edge, -1 when idle.
  logic [7:0] ship_rows  [8] = '{8'h18, 8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'h24, 8'h24};
  logic [7:0] enemy_rows [8] = '{8'h81, 8'h42, 8'h3C, 8'h5A, 8'hFF, 8'h3C, 8'h42, 8'h81};

  int m_t = -1;
  int m_x, m_y, m_sel, m_col;
  bit model_on = 0;
  int e_busy = 0, e_done = 0, e_we = 0, e_x = 0, e_y = 0, e_col = 0;
  int edge_cnt = 0;

  function automatic int sprite_bit(input int s, input int r, input int c);
    logic [7:0] rowv;
    if (s >= 2) return 1;
    rowv = (s == 0) ? ship_rows[r] : enemy_rows[r];
    return int'(rowv[7 - c]);
  endfunction

  // Reference model, advanced on every rising edge from the inputs seen there.
  always @(posedge clk) begin
    int p, r, c, px, py;
    edge_cnt++;
    if (reset) begin
      m_t = -1;
      model_on = 1;
    end else if (m_t == -1 || m_t == 65) begin
      if (go) begin
        m_t = 0; m_x = ld_x; m_y = ld_y; m_sel = sprite_sel; m_col = colour_in;
      end else begin
        m_t = -1;
      end
    end else begin
      m_t++;
    end
    e_busy = (m_t >= 0) ? 1 : 0;
    e_done = (m_t == 65) ? 1 : 0;
    e_we = 0;
    if (m_t >= 1 && m_t <= 64) begin
      p = m_t - 1; r = p / 8; c = p % 8;
      px = m_x + c; py = m_y + r;
      e_we  = (sprite_bit(m_sel, r, c) == 1 && px < 160 && py < 120) ? 1 : 0;
      e_x   = px % 256;
      e_y   = py % 128;
      e_col = (m_sel >= 2) ? 0 : m_col;
    end
  end

  // Per-command write statistics for the hand-computed checks.
  int wcount, first_x, first_y, first_edge, last_x, last_y, max_x, colour_bad, tgt_colour;
  bit first_seen;

  task automatic clear_stats(input int tgt);
    wcount = 0; first_seen = 0; first_x = -1; first_y = -1; first_edge = -1;
    last_x = -1; last_y = -1; max_x = 0; colour_bad = 0; tgt_colour = tgt;
  endtask

  // Compare DUT against the model every cycle and collect write statistics.
  always @(negedge clk) begin
    if (model_on) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("writeEn", writeEn, e_we);
      if (e_we == 1) begin
        chk("x", x, e_x);
        chk("y", y, e_y);
        chk("colour", colour, e_col);
      end
      if (writeEn) begin
        wcount++;
        if (!first_seen) begin
          first_seen = 1; first_x = x; first_y = y; first_edge = edge_cnt;
        end
        last_x = x; last_y = y;
        if (int'(x) > max_x) max_x = x;
        if (int'(colour) != tgt_colour) colour_bad++;
      end
    end
  end

  int acc_edge;

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_done_seen"}, seen, 1);
    chk({name, "_done_edge"}, edge_cnt - acc_edge, 65);
  endtask

  task automatic do_cmd(input string name, input int xi, input int yi, input int si,
                        input int ci, input int tgt);
    @(negedge clk);
    ld_x = 8'(xi); ld_y = 7'(yi); sprite_sel = 2'(si); colour_in = 3'(ci); go = 1'b1;
    clear_stats(tgt);
    acc_edge = edge_cnt + 1;
    @(negedge clk);
    go = 1'b0;
    chk({name, "_busy_rise"}, busy, 1);
    wait_done(name);
    chk({name, "_busy_in_done"}, busy, 1);
    @(negedge clk);
    chk({name, "_busy_fall"}, busy, 0);
    chk({name, "_done_once"}, done, 0);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; ld_x = 8'd0; ld_y = 7'd0; sprite_sel = 2'd0; colour_in = 3'd0;
    clear_stats(0);
    repeat (3) @(negedge clk);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_writeEn", writeEn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    do_cmd("ship", 76, 100, 0, 3'b111, 3'b111);
    chk("ship_count", wcount, 34);
    chk("ship_first_x", first_x, 79);
    chk("ship_first_y", first_y, 100);
    chk("ship_first_edge", first_edge - acc_edge, 4);
    chk("ship_last_x", last_x, 81);
    chk("ship_last_y", last_y, 107);
    chk("ship_colour", colour_bad, 0);

    do_cmd("enemy", 0, 0, 1, 3'b100, 3'b100);
    chk("enemy_count", wcount, 28);
    chk("enemy_colour", colour_bad, 0);
    chk("enemy_first_x", first_x, 0);
    chk("enemy_first_y", first_y, 0);
    chk("enemy_last_x", last_x, 7);
    chk("enemy_last_y", last_y, 7);

    do_cmd("erase", 10, 20, 2, 3'b101, 3'b000);
    chk("erase_count", wcount, 64);
    chk("erase_colour", colour_bad, 0);
    chk("erase_first_x", first_x, 10);
    chk("erase_first_y", first_y, 20);
    chk("erase_last_x", last_x, 17);
    chk("erase_last_y", last_y, 27);

    do_cmd("clipx", 156, 0, 0, 3'b001, 3'b001);
    chk("clipx_count", wcount, 17);
    chk("clipx_max_x", (max_x <= 159) ? 1 : 0, 1);

    do_cmd("clipy", 0, 116, 1, 3'b010, 3'b010);
    chk("clipy_count", wcount, 12);
    chk("clipy_last_y", last_y, 119);

    do_cmd("reserved", 30, 40, 3, 3'b110, 3'b000);
    chk("reserved_count", wcount, 64);
    chk("reserved_colour", colour_bad, 0);

    // go held high across a whole command while the origin input moves.
    @(negedge clk);
    ld_x = 8'd40; ld_y = 7'd10; sprite_sel = 2'd0; colour_in = 3'b010; go = 1'b1;
    clear_stats(3'b010);
    acc_edge = edge_cnt + 1;
    repeat (10) @(negedge clk);
    ld_x = 8'd100;
    wait_done("hold");
    chk("hold_first_x", first_x, 43);
    chk("hold_count", wcount, 34);
    clear_stats(3'b010);
    acc_edge = edge_cnt + 1;
    @(negedge clk);
    chk("hold_second_busy", busy, 1);
    chk("hold_second_done", done, 0);
    go = 1'b0;
    wait_done("hold2");
    chk("hold2_first_x", first_x, 103);
    @(negedge clk);

    // Reset while the erase scan is about to process pixel 20.
    @(negedge clk);
    ld_x = 8'd10; ld_y = 7'd20; sprite_sel = 2'd2; colour_in = 3'b111; go = 1'b1;
    clear_stats(0);
    @(negedge clk);
    go = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_count", wcount, 20);
    chk("midrst_writeEn", writeEn, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    do_cmd("after_rst", 10, 20, 2, 3'b111, 3'b000);
    chk("after_rst_count", wcount, 64);

    // Randomized traffic, including go pulses while busy.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      go         = ($urandom_range(0, 3) == 0);
      ld_x       = 8'($urandom);
      ld_y       = 7'($urandom);
      sprite_sel = 2'($urandom);
      colour_in  = 3'($urandom);
    end
    go = 1'b0;
    repeat (80) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
